// File: rtl/fibre_delay_seq_if.sv
// fibre_delay_seq_if
//   Groups the frame-control and converter-handshake signals of the fibre
//   delay sequencer into one bundle.
//   master : the frame requester / converter side. It drives frame_req,
//            core_o_en and core_wait, and observes everything else.
//   slave  : the sequencer itself.
//   Signals:
//     frame_req  - frame start request, one-cycle pulse
//     core_o_en  - converter output-word valid
//     core_wait  - converter input stall (only counted)
//     core_start - converter start pulse
//     rd_base    - read bank base address
//     wr_base    - write bank base address
//     busy       - sequencer not idle
//     frame_done - end-of-frame pulse
//     req_drop   - a request was discarded
//     word_cnt   - output words counted in the current frame
//     stall_cnt  - saturating count of core_wait cycles in the current frame
interface fibre_delay_seq_if #(
  parameter int R_ADDR_WIDTH = 14,
  parameter int W_ADDR_WIDTH = 14
);
  logic                    frame_req;
  logic                    core_o_en;
  logic                    core_wait;
  logic                    core_start;
  logic [R_ADDR_WIDTH-1:0] rd_base;
  logic [W_ADDR_WIDTH-1:0] wr_base;
  logic                    busy;
  logic                    frame_done;
  logic                    req_drop;
  logic [15:0]             word_cnt;
  logic [15:0]             stall_cnt;

  modport master (
    output frame_req, core_o_en, core_wait,
    input  core_start, rd_base, wr_base, busy, frame_done, req_drop,
           word_cnt, stall_cnt
  );

  modport slave (
    input  frame_req, core_o_en, core_wait,
    output core_start, rd_base, wr_base, busy, frame_done, req_drop,
           word_cnt, stall_cnt
  );
endinterface

// File: rtl/fibre_delay_seq.sv
// fibre_delay_seq
//   Frame sequencer for a double-buffered fibre delay converter. It starts the
//   converter, counts FRAME_LEN output words, waits for the RAM read pipeline
//   to drain (FLUSH), pulses frame_done and then swaps the read/write banks.
//   A single request that arrives while a frame is running is held pending;
//   any further request in that frame is dropped and flagged.
//   Ports:
//     clk  - single clock, everything on posedge
//     rst  - synchronous, active-high reset
//     bus  - fibre_delay_seq_if.slave (see the interface for signal meanings)
module fibre_delay_seq #(
  parameter int FRAME_LEN    = 1024,
  parameter int RAM_LATENCY  = 5,
  parameter int BANK_DEPTH   = 4096,
  parameter int R_ADDR_WIDTH = 14,
  parameter int W_ADDR_WIDTH = 14
) (
  input  logic               clk,
  input  logic               rst,
  fibre_delay_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int          FLUSH_W   = $clog2(RAM_LATENCY + 2);
  localparam logic [15:0] LAST_WORD = 16'(FRAME_LEN - 1);

  state_t             state;
  logic               pending;
  logic               rd_bank;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [15:0]        word_cnt;
  logic [15:0]        stall_cnt;
  logic               core_start;
  logic               busy;
  logic               frame_done;
  logic               req_drop;

  // NOTE: every register here is written with <= so all branches see the
  // pre-edge values; blocking = in a clocked block creates order-dependent
  // behaviour that simulation and synthesis can disagree on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      rd_bank    <= 1'b0;
      flush_cnt  <= '0;
      word_cnt   <= '0;
      stall_cnt  <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      req_drop   <= 1'b0;
    end else begin
      // Pulse outputs default low; the state branches raise them for one cycle.
      core_start <= 1'b0;
      frame_done <= 1'b0;
      req_drop   <= 1'b0;

      // A request seen while busy (DONE included) is queued once, then dropped.
      if (busy && bus.frame_req) begin
        if (pending) req_drop <= 1'b1;
        else         pending  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.frame_req || pending) begin
            state      <= START;
            core_start <= 1'b1;
            busy       <= 1'b1;
            pending    <= 1'b0;
            word_cnt   <= '0;
            stall_cnt  <= '0;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (bus.core_o_en) begin
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt == LAST_WORD) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_W'(RAM_LATENCY);
            end
          end
        end
        FLUSH: begin
          // Loaded with RAM_LATENCY, so FLUSH spans RAM_LATENCY+1 cycles.
          if (flush_cnt == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FLUSH_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          rd_bank <= ~rd_bank;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if ((state == RUN || state == FLUSH) && bus.core_wait &&
          stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.core_start = core_start;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.req_drop   = req_drop;
  assign bus.word_cnt   = word_cnt;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.rd_base    = rd_bank ? R_ADDR_WIDTH'(BANK_DEPTH) : '0;
  assign bus.wr_base    = rd_bank ? '0 : W_ADDR_WIDTH'(BANK_DEPTH);

endmodule

// File: doc/fibre_delay_seq.md
FIBRE_DELAY_SEQ -- requirements
Module: fibre_delay_seq

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, meaning output words per frame; range 1 to 65535.
REQ-002 SHALL have parameter RAM_LATENCY, default 5, meaning converter read-pipeline depth; FLUSH lasts RAM_LATENCY+1 cycles.
REQ-003 SHALL have parameter BANK_DEPTH, default 4096, meaning words per RAM bank.
REQ-004 SHALL have parameter R_ADDR_WIDTH, default 14, meaning read-base width.
REQ-005 SHALL have parameter W_ADDR_WIDTH, default 14, meaning write-base width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port frame_req, input, 1 bit: frame start request, one-cycle pulse.
REQ-009 SHALL have port core_o_en, input, 1 bit: converter output-word valid.
REQ-010 SHALL have port core_wait, input, 1 bit: converter input stall; observed only, for stall_cnt.
REQ-011 SHALL have port core_start, output, 1 bit: converter start pulse.
REQ-012 SHALL have port rd_base, output, R_ADDR_WIDTH bits: read bank base address.
REQ-013 SHALL have port wr_base, output, W_ADDR_WIDTH bits: write bank base address.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port frame_done, output, 1 bit: end-of-frame pulse.
REQ-016 SHALL have port req_drop, output, 1 bit: pulse when a request is discarded.
REQ-017 SHALL have port word_cnt, output, 16 bits: output words counted in the current frame.
REQ-018 SHALL have port stall_cnt, output, 16 bits: core_wait-high cycles in the current frame, saturating.

Function
REQ-019 SHALL implement FSM states IDLE, START, RUN, FLUSH, DONE, each registered.
REQ-020 SHALL go IDLE->START on the edge where frame_req=1 or pending=1; START lasts exactly 1 cycle.
REQ-021 SHALL drive core_start=1 only while state is START: frame_req sampled high at edge N gives core_start high for the cycle after N.
REQ-022 SHALL clear word_cnt and stall_cnt to 0 on entering START.
REQ-023 SHALL go START->RUN unconditionally.
REQ-024 In RUN, SHALL increment word_cnt by 1 on each cycle with core_o_en=1; core_o_en SHALL be ignored in IDLE, START, FLUSH and DONE.
REQ-025 SHALL go RUN->FLUSH on the cycle where core_o_en=1 and word_cnt==FRAME_LEN-1; word_cnt then holds FRAME_LEN.
REQ-026 SHALL hold FLUSH for exactly RAM_LATENCY+1 cycles using a down-counter, then go to DONE.
REQ-027 SHALL pulse frame_done=1 for the single DONE cycle, then go DONE->IDLE.
REQ-028 SHALL toggle bank bit rd_bank on leaving DONE.
REQ-029 SHALL drive rd_base = rd_bank ? BANK_DEPTH : 0.
REQ-030 SHALL drive wr_base = rd_bank ? 0 : BANK_DEPTH.
REQ-031 SHALL change rd_base and wr_base only at the DONE->IDLE edge, never mid-frame.
REQ-032 SHALL set the one-deep pending flag when frame_req=1 while busy=1 and pending=0.
REQ-033 SHALL pulse req_drop for 1 cycle, with pending unchanged, when frame_req=1 while busy=1 and pending=1.
REQ-034 SHALL clear pending on entering START.
REQ-035 SHALL service a pending request immediately from IDLE: DONE->IDLE->START with a one-cycle IDLE gap.
REQ-036 SHALL treat frame_req=1 in the same cycle as the DONE->IDLE transition as a busy request, setting pending.
REQ-037 SHALL increment stall_cnt on each core_wait=1 cycle in RUN or FLUSH, saturating at 16'hFFFF without wrap.
REQ-038 SHALL, with FRAME_LEN=1, go to FLUSH on the first core_o_en in RUN.

Reset
REQ-039 SHALL, when rst=1 at a clock edge, force state=IDLE, pending=0, rd_bank=0, word_cnt=0, stall_cnt=0, and the FLUSH counter to 0.
REQ-040 SHALL hold core_start=0, busy=0, frame_done=0, req_drop=0, rd_base=0 and wr_base=BANK_DEPTH while rst is high.
REQ-041 SHALL give rst priority over every other input, including rst asserted mid-RUN; no frame_done is produced and the bank does not toggle.

Verification
REQ-042 SHALL verify: rst, then frame_req pulse at cycle 10 -> core_start high at cycle 11 only, busy high from 11.
REQ-043 SHALL verify: FRAME_LEN=4, RAM_LATENCY=5, core_o_en high every cycle from RUN -> FLUSH after 4 words, frame_done 6 cycles later, rd_base 0->4096, wr_base 4096->0.
REQ-044 SHALL verify: two frame_req pulses during RUN -> first sets pending, second gives req_drop=1; after DONE, core_start reasserts 2 cycles after frame_done.
REQ-045 SHALL verify: rst asserted mid-RUN with word_cnt=2 -> next cycle IDLE, word_cnt=0, rd_base=0, no frame_done.
REQ-046 SHALL verify: core_wait held high 70000 cycles in RUN -> stall_cnt=65535.
REQ-047 SHALL verify: core_o_en pulses while IDLE -> word_cnt stays 0 and no state change.
